// File: rtl/pmips_ld_pkg.sv
// pmips_ld_pkg
// Constants and types shared by the PMIPS program loader, the instruction
// RAM and the fetch stage.
//   BYTE_W / WORD_W / ADDR_W : byte, instruction-word and byte-address widths
//   HEADER_BYTE              : frame start marker recognised only while idle
//   ld_state_t               : loader FSM state encoding
package pmips_ld_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [BYTE_W-1:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK
  } ld_state_t;

endpackage

// File: rtl/im_loader.sv
// im_loader
// Loads a program into the PMIPS instruction RAM from a framed byte stream:
//   A5, N, N words (high byte first), 8-bit checksum of the 2N data bytes.
// The processor is held in reset from the header until a good checksum.
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-low reset
//   rx_data    incoming byte
//   rx_valid   rx_data valid this cycle
//   rx_ready   loader accepts a byte (low only during a RAM write cycle)
//   im_we      instruction RAM write enable, one cycle per word
//   im_waddr   byte address of the write (always even)
//   im_wdata   instruction word to write
//   cpu_hold   processor held in reset
//   load_done  one-cycle pulse after a successful load
//   load_err   sticky error flag, cleared by the next header
module im_loader
  import pmips_ld_pkg::*;
#(
  parameter int                MAX_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  // Nine bits so that a limit of 256 is representable against an 8-bit count.
  localparam logic [8:0]        MAX_LIMIT = 9'(MAX_WORDS);
  // Word-aligned base; bit 0 of a byte address never reaches the RAM.
  localparam logic [ADDR_W-1:0] BASE_EVEN = {BASE_ADDR[ADDR_W-1:1], 1'b0};

  ld_state_t         state, state_n;
  logic [BYTE_W-1:0] count, count_n;
  logic [BYTE_W-1:0] index, index_n;
  logic [BYTE_W-1:0] hi, hi_n;
  logic [BYTE_W-1:0] sum, sum_n;
  logic              ready_n, we_n, hold_n, done_n, err_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [WORD_W-1:0] wdata_n;
  logic              accept;

  assign accept = rx_valid && rx_ready;

  // Every output is registered: the next-state logic computes next values,
  // so im_we and rx_ready line up exactly with the WRITE state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      count     <= '0;
      index     <= '0;
      hi        <= '0;
      sum       <= '0;
      rx_ready  <= 1'b1;
      im_we     <= 1'b0;
      im_waddr  <= '0;
      im_wdata  <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      index     <= index_n;
      hi        <= hi_n;
      sum       <= sum_n;
      rx_ready  <= ready_n;
      im_we     <= we_n;
      im_waddr  <= waddr_n;
      im_wdata  <= wdata_n;
      cpu_hold  <= hold_n;
      load_done <= done_n;
      load_err  <= err_n;
    end
  end

  // Next-state and next-output logic. Registers hold by default; im_we and
  // load_done are pulses and default low.
  always_comb begin
    state_n = state;
    count_n = count;
    index_n = index;
    hi_n    = hi;
    sum_n   = sum;
    we_n    = 1'b0;
    waddr_n = im_waddr;
    wdata_n = im_wdata;
    hold_n  = cpu_hold;
    done_n  = 1'b0;
    err_n   = load_err;

    case (state)
      S_IDLE: begin
        if (accept && rx_data == HEADER_BYTE) begin
          state_n = S_COUNT;
          hold_n  = 1'b1;
          err_n   = 1'b0;
          sum_n   = '0;
          index_n = '0;
        end
      end

      S_COUNT: begin
        if (accept) begin
          if (rx_data == '0 || {1'b0, rx_data} > MAX_LIMIT) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            count_n = rx_data;
            state_n = S_HI;
          end
        end
      end

      S_HI: begin
        if (accept) begin
          hi_n    = rx_data;
          sum_n   = sum + rx_data;
          state_n = S_LO;
        end
      end

      // The write is set up here so it appears in the WRITE cycle itself.
      S_LO: begin
        if (accept) begin
          sum_n   = sum + rx_data;
          we_n    = 1'b1;
          waddr_n = BASE_EVEN + {7'd0, index, 1'b0};
          wdata_n = {hi, rx_data};
          state_n = S_WRITE;
        end
      end

      // index < count <= 255 here, so index + 1 cannot overflow 8 bits.
      S_WRITE: begin
        index_n = index + 8'd1;
        state_n = (index + 8'd1 == count) ? S_CHECK : S_HI;
      end

      S_CHECK: begin
        if (accept) begin
          if (rx_data == sum) begin
            done_n = 1'b1;
            hold_n = 1'b0;
          end else begin
            err_n  = 1'b1;
          end
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase

    ready_n = (state_n != S_WRITE);
  end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader
// Self-checking bench for im_loader. Three instances share the byte stream:
// dut0 default parameters, dut1 with MAX_WORDS=8, dut2 with BASE_ADDR=FFFC.
// The instance under observation is chosen with sel. Expected RAM writes are
// queued when the LO byte is driven and compared when im_we is seen.
module tb_im_loader;
  import pmips_ld_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        rdy   [3];
  logic        we    [3];
  logic [15:0] waddr [3];
  logic [15:0] wdata [3];
  logic        hold  [3];
  logic        done  [3];
  logic        err   [3];

  logic [1:0]  sel;
  logic        m_ready, m_we, m_hold, m_done, m_err;
  logic [15:0] m_waddr, m_wdata;

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          we_due = 1'b0;
  logic [31:0] sb [$];
  logic [15:0] fw [$];

  always #5 clock = ~clock;

  im_loader dut0 (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy[0]), .im_we(we[0]), .im_waddr(waddr[0]), .im_wdata(wdata[0]),
    .cpu_hold(hold[0]), .load_done(done[0]), .load_err(err[0])
  );

  im_loader #(.MAX_WORDS(8)) dut1 (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy[1]), .im_we(we[1]), .im_waddr(waddr[1]), .im_wdata(wdata[1]),
    .cpu_hold(hold[1]), .load_done(done[1]), .load_err(err[1])
  );

  im_loader #(.BASE_ADDR(16'hFFFC)) dut2 (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy[2]), .im_we(we[2]), .im_waddr(waddr[2]), .im_wdata(wdata[2]),
    .cpu_hold(hold[2]), .load_done(done[2]), .load_err(err[2])
  );

  // Route the observed instance onto the m_* signals.
  always_comb begin
    m_ready = rdy[0]; m_we = we[0]; m_waddr = waddr[0]; m_wdata = wdata[0];
    m_hold  = hold[0]; m_done = done[0]; m_err = err[0];
    case (sel)
      2'd1: begin
        m_ready = rdy[1]; m_we = we[1]; m_waddr = waddr[1]; m_wdata = wdata[1];
        m_hold  = hold[1]; m_done = done[1]; m_err = err[1];
      end
      2'd2: begin
        m_ready = rdy[2]; m_we = we[2]; m_waddr = waddr[2]; m_wdata = wdata[2];
        m_hold  = hold[2]; m_done = done[2]; m_err = err[2];
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-cycle monitor: im_we must appear exactly in the cycle after a LO
  // byte is taken, rx_ready must be low only then, and each write is
  // matched against the scoreboard.
  always @(negedge clock) begin
    if (mon_en) begin
      checkOutput("we_pulse", 32'(m_we), 32'(we_due));
      checkOutput("ready", 32'(m_ready), 32'(!we_due));
      if (m_we && sb.size() > 0) begin
        logic [31:0] e;
        e = sb.pop_front();
        checkOutput("waddr", 32'(m_waddr), 32'(e[31:16]));
        checkOutput("wdata", 32'(m_wdata), 32'(e[15:0]));
      end
      we_due = 1'b0;
    end
  end

  // Drive one byte after an optional random idle gap and wait for it to be
  // taken. Returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, input bit is_lo,
                               input int gapmax);
    int gap;
    int n;
    gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (gap) begin
      @(negedge clock);
      rx_valid = 1'b0;
    end
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!m_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("ready_wait", 32'(n < 20), 32'd1);
    @(posedge clock);
    if (is_lo) we_due = 1'b1;
  endtask

  task automatic idleCycle();
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    reset    = 1'b1;
  endtask

  function automatic logic [7:0] frameSum();
    logic [7:0] s;
    s = 8'h00;
    foreach (fw[i]) s = s + fw[i][15:8] + fw[i][7:0];
    return s;
  endfunction

  // Send a full frame from the words in fw and check the outcome.
  task automatic sendFrame(input logic [7:0] cnt, input logic [7:0] chk,
                           input int gapmax, input logic [15:0] base,
                           input bit ok);
    applyStimulus(HEADER_BYTE, 1'b0, gapmax);
    idleCycle();
    checkOutput("hold_on_hdr", 32'(m_hold), 32'd1);
    checkOutput("err_clr_hdr", 32'(m_err), 32'd0);
    applyStimulus(cnt, 1'b0, gapmax);
    foreach (fw[i]) begin
      applyStimulus(fw[i][15:8], 1'b0, gapmax);
      sb.push_back({base + 16'(2 * i), fw[i]});
      applyStimulus(fw[i][7:0], 1'b1, gapmax);
    end
    applyStimulus(chk, 1'b0, gapmax);
    idleCycle();
    checkOutput("done_pulse", 32'(m_done), 32'(ok));
    checkOutput("hold_end", 32'(m_hold), 32'(!ok));
    checkOutput("err_end", 32'(m_err), 32'(!ok));
    idleCycle();
    checkOutput("done_clear", 32'(m_done), 32'd0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(m_ready), 32'd1);
    checkOutput({tag, "_we"},    32'(m_we),    32'd0);
    checkOutput({tag, "_waddr"}, 32'(m_waddr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(m_wdata), 32'd0);
    checkOutput({tag, "_hold"},  32'(m_hold),  32'd0);
    checkOutput({tag, "_done"},  32'(m_done),  32'd0);
    checkOutput({tag, "_err"},   32'(m_err),   32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    sel      = 2'd0;

    // Reset state
    repeat (2) @(negedge clock);
    checkResetValues("rst");
    sel = 2'd2;
    checkOutput("rst_waddr_base", 32'(m_waddr), 32'd0);
    sel = 2'd0;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Good three-word frame
    $display("[TB] good frame");
    fw = '{16'h6003, 16'h0004, 16'h2443};
    sendFrame(8'd3, 8'hCE, 0, 16'h0000, 1'b1);

    // Bad checksum, then recovery with a good frame
    $display("[TB] bad checksum then recovery");
    sendFrame(8'd3, 8'hCF, 0, 16'h0000, 1'b0);
    sendFrame(8'd3, 8'hCE, 0, 16'h0000, 1'b1);

    // Garbage before a header, then a zero count
    $display("[TB] garbage bytes and bad counts");
    doReset();
    applyStimulus(8'h00, 1'b0, 0);
    applyStimulus(8'hFF, 1'b0, 0);
    applyStimulus(8'h5A, 1'b0, 0);
    idleCycle();
    checkOutput("garbage_hold", 32'(m_hold), 32'd0);
    checkOutput("garbage_err", 32'(m_err), 32'd0);
    applyStimulus(HEADER_BYTE, 1'b0, 0);
    applyStimulus(8'h00, 1'b0, 0);
    idleCycle();
    checkOutput("cnt0_err", 32'(m_err), 32'd1);
    checkOutput("cnt0_hold", 32'(m_hold), 32'd1);

    // Count above MAX_WORDS=8, then exactly 8 accepted
    doReset();
    sel = 2'd1;
    applyStimulus(HEADER_BYTE, 1'b0, 0);
    applyStimulus(8'h09, 1'b0, 0);
    idleCycle();
    checkOutput("cnt9_err", 32'(m_err), 32'd1);
    checkOutput("cnt9_hold", 32'(m_hold), 32'd1);
    fw = '{16'h0101, 16'h0202, 16'h0303, 16'h0404,
           16'h0505, 16'h0606, 16'h0707, 16'hF0F8};
    sendFrame(8'd8, frameSum(), 0, 16'h0000, 1'b1);

    // Random rx_valid gaps across a four-word frame
    $display("[TB] random gaps");
    doReset();
    sel = 2'd0;
    fw = '{16'h8C21, 16'h1F3E, 16'hA5FF, 16'h0000};
    sendFrame(8'd4, frameSum(), 5, 16'h0000, 1'b1);

    // Reset after the second word's HI byte, then a fresh frame
    $display("[TB] reset mid-frame");
    applyStimulus(HEADER_BYTE, 1'b0, 0);
    applyStimulus(8'h02, 1'b0, 0);
    applyStimulus(8'h11, 1'b0, 0);
    sb.push_back({16'h0000, 16'h1122});
    applyStimulus(8'h22, 1'b1, 0);
    applyStimulus(8'h33, 1'b0, 0);
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    checkResetValues("midrst");
    checkOutput("midrst_sb", 32'(sb.size()), 32'd0);
    reset = 1'b1;
    fw = '{16'h1357, 16'h2468};
    sendFrame(8'd2, frameSum(), 0, 16'h0000, 1'b1);

    // Address wrap from FFFC, with A5 bytes as ordinary data
    $display("[TB] address wrap");
    doReset();
    sel = 2'd2;
    fw = '{16'h1234, 16'hA5A5, 16'hBEEF};
    sendFrame(8'd3, frameSum(), 0, 16'hFFFC, 1'b1);

    repeat (2) idleCycle();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Program loader for the PMIPS instruction memory: accepts a framed byte stream (from the board UART receiver), assembles 16-bit instructions, and writes them into the writable instruction RAM. It holds the processor in reset while a program is loaded. It is the write side of the same word-addressed memory that the fetch stage reads (byte address, word index = addr[15:1]).

## Interface
- `MAX_WORDS`, 256: largest accepted program length in words (1..256).
- `BASE_ADDR`, 16'h0000: byte address of the first written word; must be even.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid this cycle.
- `rx_ready`  out  1  loader accepts byte; a transfer occurs when `rx_valid && rx_ready`.
- `im_we`  out  1  instruction RAM write enable, one cycle per word.
- `im_waddr`  out  16  byte address of write; always even.
- `im_wdata`  out  16  instruction word.
- `cpu_hold`  out  1  processor held in reset.
- `load_done`  out  1  one-cycle pulse on a successful load.
- `load_err`  out  1  sticky error flag.

## Operation
- Frame: header 8'hA5, count N (1..255; words), N words sent high byte first, then checksum byte = 8-bit sum of all 2N data bytes.
- States: IDLE, COUNT, HI, LO, WRITE, CHECK.
- IDLE: bytes other than 8'hA5 are accepted and discarded. On 8'hA5, go to COUNT, set `cpu_hold`=1, clear `load_err`, clear sum, word index = 0.
- COUNT: N==0 or N>MAX_WORDS → set `load_err`, go to IDLE (`cpu_hold` stays 1). Otherwise latch N and go to HI.
- HI: latch the high byte, add it to the sum, and go to LO.
- LO: latch the low byte, add it to the sum, and go to WRITE.
- WRITE: `im_we`=1, `im_waddr`=BASE_ADDR+2*index, `im_wdata`={hi,lo}. Increment index. If index+1==N go to CHECK, else go to HI.
- CHECK: received byte == sum → `load_done` pulse, `cpu_hold`=0, go to IDLE. Mismatch → `load_err`=1, `cpu_hold` stays 1, go to IDLE. Words already written are not rolled back.
- Sum is 8-bit and wraps modulo 256. Address arithmetic is 16-bit and wraps.
- A new header re-arms the loader only from IDLE. Inside a frame, 8'hA5 is ordinary data.

## Timing
- Reset values: state IDLE, `rx_ready`=1, `im_we`=0, `im_waddr`=0, `im_wdata`=0, `cpu_hold`=0, `load_done`=0, `load_err`=0, internal sum and index 0.
- `rx_ready`=1 in every state except WRITE, where it is 0 for exactly one cycle.
- All outputs are registered.
  - LO byte accepted at edge t → `im_we` high during cycle t+1 → HI or CHECK active at t+2.
  - Checksum byte accepted at edge t → `load_done` high and `cpu_hold` low during cycle t+1.
  - `load_err` also rises during cycle t+1 of the offending byte.
- `rx_valid` low stalls any state indefinitely with no timeout. Outputs hold, and `im_we` never repeats.
- Reset asserted mid-frame: the next edge returns all outputs to reset values. A WRITE in that cycle is abandoned (`im_we`=0). The partial program remains in RAM.
- Minimum frame time: 3 + 3N cycles with `rx_valid` held high.

## Structure
- Shared package `pmips_ld_pkg` holds:
  - state encoding;
  - header constant 8'hA5;
  - word/byte width constants shared with the instruction RAM and fetch stage.
- Single module; no sub-module needed. Checksum accumulator and word assembler are inline registers.

## Test plan
- Reset, then frame A5,03,60,03, 00,04, 24,43, chk=CE:
  - im_we pulses write 0x6003@0, 0x0004@2, 0x2443@4;
  - `load_done` one cycle;
  - `cpu_hold` 1→0;
  - `load_err`=0.
- Same frame with chk=CF: all three writes occur, `load_err`=1, `cpu_hold`=1, no `load_done`. A following valid frame clears `load_err` and pulses `load_done`.
- Garbage bytes 00,FF,5A before the header are ignored: no writes, `cpu_hold`=0. Also check count=0, and count=9 with MAX_WORDS=8: immediate `load_err`=1, no writes.
- Random `rx_valid` gaps (0–5 idle cycles) across a 4-word frame:
  - identical writes and addresses;
  - `rx_ready` low only in WRITE cycles;
  - exactly one `im_we` per word.
- Reset asserted after the second word's HI byte: next cycle all outputs at reset values. Resume with a fresh full frame, which loads correctly from BASE_ADDR.
- BASE_ADDR=16'hFFFC, 3 words: addresses FFFC, FFFE, 0000 (wrap). Data bytes A5,A5 inside the frame are written as 0xA5A5, not treated as a header.
